hazard_unit: RTL and testbench
==============================

Name: hazard_unit

Overview:
- Pipeline hazard controller for the 5-stage pipelined CPU, in the E stage.
- Generates the 2-bit forwarding selects consumed by the E-stage source-operand forwarding muxes.
- Generates stall/flush controls for the F/D, D/E, E/M and M/W pipeline registers.
- Sequences a data-memory wait-state FSM and keeps a saturating stall-cycle performance counter.

Parameters:
- ADDR_W, 5: register-index width.
- MEM_WAIT, 2: extra stall cycles per data-memory access in M. 0 disables the wait FSM.
- CNT_W, 32: StallCount width.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- Rs1D, Rs2D  in  ADDR_W  D-stage source registers
- Rs1E, Rs2E, RdE  in  ADDR_W  E-stage sources and destination
- RdM, RdW  in  ADDR_W  M-stage and W-stage destinations
- RegWriteM, RegWriteW  in  1  register write enables, M and W stages
- ResultSrcE0  in  1  instruction in E is a load
- PCSrcE  in  1  taken branch/jump resolved in E
- MemAccessM  in  1  load/store in M
- ForwardAE, ForwardBE  out  2  operand select: 00 RegFile, 01 ResultW, 10 ALUOutM
- StallF, StallD, StallE, StallM  out  1  hold the named pipeline register
- FlushD, FlushE, FlushW  out  1  insert a bubble into the named register
- StallCount  out  CNT_W  cycles with StallF=1

Behaviour:
Reset and timing
- One clock, clk.
- rst_n low asynchronously forces: FSM=IDLE, cnt=0, StallCount=0.
- All other outputs are combinational from the inputs and the FSM state.

Forwarding (combinational, zero latency)
- ForwardAE = 10 if RegWriteM && RdM!=0 && RdM==Rs1E.
- Else 01 if RegWriteW && RdW!=0 && RdW==Rs1E.
- Else 00.
- ForwardBE is identical, using Rs2E.
- M has priority over W. 11 is never driven. Register x0 is never forwarded.

Load-use
- lwStall = ResultSrcE0 && RdE!=0 && (RdE==Rs1D || RdE==Rs2D).

Wait FSM (states IDLE, WAIT, DONE; down-counter cnt)
- IDLE:
  - If MemAccessM && MEM_WAIT!=0: memStall=1 and cnt<=MEM_WAIT-1.
  - Next state is WAIT if MEM_WAIT>1, else DONE.
  - Otherwise memStall=0 and the FSM stays in IDLE.
- WAIT: memStall=1. If cnt==1, go to DONE; else cnt<=cnt-1.
- DONE: memStall=0; the instruction advances. Always go to IDLE next cycle.
- A back-to-back access is evaluated freshly in IDLE.
- The M-stage access occupies exactly MEM_WAIT+1 cycles, of which MEM_WAIT are stalled.

Stall and flush outputs
- StallF = StallD = lwStall | memStall.
- StallE = StallM = FlushW = memStall. A bubble enters W while M is held.
- FlushD = PCSrcE & ~memStall.
- FlushE = (lwStall | PCSrcE) & ~memStall.
- While memStall is high, the branch in E is held. Its flushes apply on the first non-stalled cycle.
- PCSrcE together with lwStall: FlushE=1 and StallF=StallD=1. The fetch redirect comes from the datapath.

StallCount
- Increments on each clk edge with StallF=1.
- Saturates at all-ones; no wrap.

Reset mid-access
- Asserting rst_n during WAIT forces IDLE immediately.
- memStall drops the same cycle unless MemAccessM is high (IDLE rule).

Test Plan:
- Forwarding priority: RegWriteM=RegWriteW=1, RdM=RdW=Rs1E=5 -> ForwardAE=10. With RegWriteM=0 -> 01. With RdM=RdW=0 -> 00.
- Load-use: ResultSrcE0=1, RdE=7, Rs2D=7 -> StallF=StallD=FlushE=1, StallE=0. Lasts exactly one cycle once E advances.
- Branch: PCSrcE=1, MemAccessM=0 -> FlushD=FlushE=1, no stalls. With MemAccessM=1 and MEM_WAIT=2 -> flushes suppressed 2 cycles, asserted on the 3rd.
- Wait states:
  - MEM_WAIT=2, MemAccessM held 3 cycles -> StallF/D/E/M and FlushW high for cycles 1-2, low in cycle 3, StallCount +2.
  - Back-to-back accesses -> 2 stalls each.
  - MEM_WAIT=0 -> never stalls.
- Reset mid-WAIT: drop rst_n in WAIT -> outputs return to IDLE values without waiting for clk, StallCount=0. Release rst_n -> normal operation.
- Saturation: CNT_W=4, StallF held 20 cycles -> StallCount stops at 15.

Source files
------------

// File: rtl/hazard_unit.sv
// E-stage hazard controller: operand forwarding selects, load-use and data-memory wait-state
// stalls/flushes, plus a saturating count of fetch-stall cycles.
module hazard_unit #(
  parameter int ADDR_W   = 5,
  parameter int MEM_WAIT = 2,
  parameter int CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] Rs1D,
  input  logic [ADDR_W-1:0] Rs2D,
  input  logic [ADDR_W-1:0] Rs1E,
  input  logic [ADDR_W-1:0] Rs2E,
  input  logic [ADDR_W-1:0] RdE,
  input  logic [ADDR_W-1:0] RdM,
  input  logic [ADDR_W-1:0] RdW,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic              ResultSrcE0,
  input  logic              PCSrcE,
  input  logic              MemAccessM,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              StallM,
  output logic              FlushD,
  output logic              FlushE,
  output logic              FlushW,
  output logic [CNT_W-1:0]  StallCount
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_e;

  // cnt only ever holds values up to MEM_WAIT-1
  localparam int CW = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'((MEM_WAIT > 0) ? MEM_WAIT - 1 : 0);

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [CNT_W-1:0]   stall_count_q, stall_count_d;
  logic               mem_stall;
  logic               lw_stall;

  always_comb begin
    ForwardAE = 2'b00;
    if (RegWriteM && (RdM != '0) && (RdM == Rs1E))
      ForwardAE = 2'b10;
    else if (RegWriteW && (RdW != '0) && (RdW == Rs1E))
      ForwardAE = 2'b01;
  end

  always_comb begin
    ForwardBE = 2'b00;
    if (RegWriteM && (RdM != '0) && (RdM == Rs2E))
      ForwardBE = 2'b10;
    else if (RegWriteW && (RdW != '0) && (RdW == Rs2E))
      ForwardBE = 2'b01;
  end

  assign lw_stall = ResultSrcE0 && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));

  // The first stalled cycle is spent in IDLE, so WAIT covers the remaining MEM_WAIT-1
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_stall = 1'b0;
    case (state_q)
      IDLE: begin
        if (MemAccessM && (MEM_WAIT != 0)) begin
          mem_stall = 1'b1;
          cnt_d     = CNT_INIT;
          state_d   = (MEM_WAIT > 1) ? WAIT : DONE;
        end
      end
      WAIT: begin
        mem_stall = 1'b1;
        if (cnt_q == CW'(1))
          state_d = DONE;
        else
          cnt_d = cnt_q - CW'(1);
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign StallF = lw_stall | mem_stall;
  assign StallD = lw_stall | mem_stall;
  assign StallE = mem_stall;
  assign StallM = mem_stall;
  assign FlushW = mem_stall;
  assign FlushD = PCSrcE & ~mem_stall;
  assign FlushE = (lw_stall | PCSrcE) & ~mem_stall;

  always_comb begin
    stall_count_d = stall_count_q;
    if (StallF && (stall_count_q != '1))
      stall_count_d = stall_count_q + CNT_W'(1);
  end

  assign StallCount = stall_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      stall_count_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      stall_count_q <= stall_count_d;
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: main instance (MEM_WAIT=2), a MEM_WAIT=0 instance and a
// 4-bit counter instance share stimulus; expectations are queued as inputs are driven.
module tb_hazard_unit;

  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic          RegWriteM, RegWriteW, ResultSrcE0, PCSrcE, MemAccessM;

  logic [1:0]  fa_m, fb_m, fa_z, fb_z, fa_s, fb_s;
  logic        sf_m, sd_m, se_m, sm_m, fd_m, fe_m, fw_m;
  logic        sf_z, sd_z, se_z, sm_z, fd_z, fe_z, fw_z;
  logic        sf_s, sd_s, se_s, sm_s, fd_s, fe_s, fw_s;
  logic [31:0] cnt_m, cnt_z;
  logic [3:0]  cnt_s;
  logic [10:0] ctl_m, ctl_z, ctl_s;

  assign ctl_m = {fa_m, fb_m, sf_m, sd_m, se_m, sm_m, fd_m, fe_m, fw_m};
  assign ctl_z = {fa_z, fb_z, sf_z, sd_z, se_z, sm_z, fd_z, fe_z, fw_z};
  assign ctl_s = {fa_s, fb_s, sf_s, sd_s, se_s, sm_s, fd_s, fe_s, fw_s};

  typedef struct {
    string       tag;
    logic [10:0] ctl;
    logic [31:0] cnt;
  } exp_t;

  typedef struct {
    logic          rwm, rww;
    logic [AW-1:0] rdm, rdw, rs1e, rs2e;
    logic [1:0]    fa, fb;
  } fwd_vec_t;

  exp_t        sb[$];
  logic [3:0]  sat_sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_cnt;

  hazard_unit #(.ADDR_W(AW), .MEM_WAIT(2), .CNT_W(32)) u_main (
    .clk(clk), .rst_n(rst_n), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .ResultSrcE0(ResultSrcE0), .PCSrcE(PCSrcE), .MemAccessM(MemAccessM),
    .ForwardAE(fa_m), .ForwardBE(fb_m), .StallF(sf_m), .StallD(sd_m), .StallE(se_m),
    .StallM(sm_m), .FlushD(fd_m), .FlushE(fe_m), .FlushW(fw_m), .StallCount(cnt_m));

  hazard_unit #(.ADDR_W(AW), .MEM_WAIT(0), .CNT_W(32)) u_nowait (
    .clk(clk), .rst_n(rst_n), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .ResultSrcE0(ResultSrcE0), .PCSrcE(PCSrcE), .MemAccessM(MemAccessM),
    .ForwardAE(fa_z), .ForwardBE(fb_z), .StallF(sf_z), .StallD(sd_z), .StallE(se_z),
    .StallM(sm_z), .FlushD(fd_z), .FlushE(fe_z), .FlushW(fw_z), .StallCount(cnt_z));

  hazard_unit #(.ADDR_W(AW), .MEM_WAIT(2), .CNT_W(4)) u_sat (
    .clk(clk), .rst_n(rst_n), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .ResultSrcE0(ResultSrcE0), .PCSrcE(PCSrcE), .MemAccessM(MemAccessM),
    .ForwardAE(fa_s), .ForwardBE(fb_s), .StallF(sf_s), .StallD(sd_s), .StallE(se_s),
    .StallM(sm_s), .FlushD(fd_s), .FlushE(fe_s), .FlushW(fw_s), .StallCount(cnt_s));

  always #5 clk = ~clk;

  // Packs {ForwardAE, ForwardBE, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}
  function automatic logic [10:0] mk(input logic [1:0] fa, input logic [1:0] fb,
                                     input logic sfd, input logic mem,
                                     input logic fd, input logic fe);
    return {fa, fb, sfd, sfd, mem, mem, fd, fe, mem};
  endfunction

  task automatic idle_inputs();
    Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0; RdE = '0; RdM = '0; RdW = '0;
    RegWriteM = 1'b0; RegWriteW = 1'b0; ResultSrcE0 = 1'b0; PCSrcE = 1'b0; MemAccessM = 1'b0;
  endtask

  // Count seen at a sample reflects edges before it; a stalled sample adds one for the next
  task automatic push(input string tag, input logic [10:0] ctl);
    sb.push_back('{tag: tag, ctl: ctl, cnt: exp_cnt});
    if (ctl[6]) exp_cnt = exp_cnt + 1;
  endtask

  task automatic reset_pulse();
    @(posedge clk); #1;
    idle_inputs();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    exp_cnt = '0;
  endtask

  task automatic test_reset();
    exp_t e;
    idle_inputs();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    exp_cnt = '0;
    push("reset", 11'b0);
    #1;
    e = sb.pop_front();
    checks++;
    if (ctl_m !== e.ctl) begin
      errors++; $display("[TB] FAIL %s ctl got %b want %b", e.tag, ctl_m, e.ctl);
    end
    checks++;
    if (cnt_m !== e.cnt || cnt_z !== 32'd0 || cnt_s !== 4'd0) begin
      errors++; $display("[TB] FAIL %s StallCount got %0d/%0d/%0d want 0", e.tag, cnt_m, cnt_z, cnt_s);
    end
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_forwarding();
    fwd_vec_t v[7];
    exp_t e;
    v[0] = '{1'b1, 1'b1, 5'd5, 5'd5, 5'd5, 5'd5, 2'b10, 2'b10};
    v[1] = '{1'b0, 1'b1, 5'd5, 5'd5, 5'd5, 5'd5, 2'b01, 2'b01};
    v[2] = '{1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 5'd0, 2'b00, 2'b00};
    v[3] = '{1'b1, 1'b1, 5'd3, 5'd4, 5'd3, 5'd4, 2'b10, 2'b01};
    v[4] = '{1'b1, 1'b1, 5'd6, 5'd8, 5'd7, 5'd8, 2'b00, 2'b01};
    v[5] = '{1'b0, 1'b0, 5'd5, 5'd5, 5'd5, 5'd5, 2'b00, 2'b00};
    v[6] = '{1'b1, 1'b0, 5'd2, 5'd2, 5'd9, 5'd2, 2'b00, 2'b10};
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      idle_inputs();
      RegWriteM = v[i].rwm; RegWriteW = v[i].rww;
      RdM = v[i].rdm; RdW = v[i].rdw; Rs1E = v[i].rs1e; Rs2E = v[i].rs2e;
      push($sformatf("fwd%0d", i), mk(v[i].fa, v[i].fb, 1'b0, 1'b0, 1'b0, 1'b0));
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (ctl_m !== e.ctl) begin
        errors++; $display("[TB] FAIL %s ctl got %b want %b", e.tag, ctl_m, e.ctl);
      end
    end
  endtask

  task automatic test_load_use();
    exp_t e;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      idle_inputs();
      case (i)
        0: begin ResultSrcE0 = 1'b1; RdE = 5'd7; Rs2D = 5'd7;
                 push("lw_stall", mk(2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1)); end
        1: push("lw_advanced", 11'b0);
        2: begin ResultSrcE0 = 1'b1; push("lw_x0", 11'b0); end
        3: begin ResultSrcE0 = 1'b1; RdE = 5'd12; Rs1D = 5'd12;
                 push("lw_rs1", mk(2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1)); end
        4: begin RdE = 5'd12; Rs1D = 5'd12; push("not_load", 11'b0); end
        default: begin ResultSrcE0 = 1'b1; RdE = 5'd3; Rs1D = 5'd3; PCSrcE = 1'b1;
                 push("lw_branch", mk(2'b00, 2'b00, 1'b1, 1'b0, 1'b1, 1'b1)); end
      endcase
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (ctl_m !== e.ctl) begin
        errors++; $display("[TB] FAIL %s ctl got %b want %b", e.tag, ctl_m, e.ctl);
      end
      checks++;
      if (cnt_m !== e.cnt) begin
        errors++; $display("[TB] FAIL %s StallCount got %0d want %0d", e.tag, cnt_m, e.cnt);
      end
    end
  endtask

  task automatic test_branch();
    exp_t e;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      idle_inputs();
      PCSrcE     = (i < 4);
      MemAccessM = (i >= 1 && i <= 3);
      case (i)
        0:       push("br_plain", mk(2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1));
        1, 2:    push($sformatf("br_held%0d", i), mk(2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0));
        3:       push("br_release", mk(2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1));
        default: push("br_idle", 11'b0);
      endcase
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (ctl_m !== e.ctl) begin
        errors++; $display("[TB] FAIL %s ctl got %b want %b", e.tag, ctl_m, e.ctl);
      end
      checks++;
      if (cnt_m !== e.cnt) begin
        errors++; $display("[TB] FAIL %s StallCount got %0d want %0d", e.tag, cnt_m, e.cnt);
      end
    end
  endtask

  // One 3-cycle access, then back-to-back accesses, then an idle cycle
  task automatic test_wait_states();
    exp_t e;
    logic [2:0] pat [10] = '{1, 1, 0, 1, 1, 0, 1, 1, 0, 0};
    logic       acc [10] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      idle_inputs();
      MemAccessM = acc[i];
      push($sformatf("wait%0d", i), mk(2'b00, 2'b00, pat[i][0], pat[i][0], 1'b0, 1'b0));
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (ctl_m !== e.ctl) begin
        errors++; $display("[TB] FAIL %s ctl got %b want %b", e.tag, ctl_m, e.ctl);
      end
      checks++;
      if (cnt_m !== e.cnt) begin
        errors++; $display("[TB] FAIL %s StallCount got %0d want %0d", e.tag, cnt_m, e.cnt);
      end
    end
  endtask

  task automatic test_mem_wait0();
    exp_t e;
    reset_pulse();
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      idle_inputs();
      MemAccessM = 1'b1;
      PCSrcE     = (i >= 2);
      sb.push_back('{tag: $sformatf("nowait%0d", i),
                     ctl: mk(2'b00, 2'b00, 1'b0, 1'b0, i >= 2, i >= 2), cnt: 32'd0});
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (ctl_z !== e.ctl) begin
        errors++; $display("[TB] FAIL %s ctl got %b want %b", e.tag, ctl_z, e.ctl);
      end
      checks++;
      if (cnt_z !== e.cnt) begin
        errors++; $display("[TB] FAIL %s StallCount got %0d want %0d", e.tag, cnt_z, e.cnt);
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    exp_t e;
    reset_pulse();
    for (int i = 0; i < 7; i++) begin
      if (i == 2) begin
        #1 rst_n = 1'b0;
        exp_cnt = '0;
        push("mid_reset", 11'b0);
        #1;
      end else begin
        if (i == 3) begin
          @(posedge clk); #1;
          rst_n = 1'b1;
        end
        @(posedge clk); #1;
        idle_inputs();
        MemAccessM = (i == 0) || (i >= 3 && i <= 5);
        if (i == 0 || i == 1 || i == 3 || i == 4)
          push($sformatf("rmw%0d", i), mk(2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0));
        else
          push($sformatf("rmw%0d", i), 11'b0);
        @(negedge clk);
      end
      e = sb.pop_front();
      checks++;
      if (ctl_m !== e.ctl) begin
        errors++; $display("[TB] FAIL %s ctl got %b want %b", e.tag, ctl_m, e.ctl);
      end
      checks++;
      if (cnt_m !== e.cnt) begin
        errors++; $display("[TB] FAIL %s StallCount got %0d want %0d", e.tag, cnt_m, e.cnt);
      end
    end
  endtask

  task automatic test_saturation();
    exp_t       e;
    logic [3:0] s;
    reset_pulse();
    for (int i = 0; i < 22; i++) begin
      @(posedge clk); #1;
      idle_inputs();
      if (i < 20) begin
        ResultSrcE0 = 1'b1; RdE = 5'd7; Rs1D = 5'd7;
      end
      sat_sb.push_back((i > 15) ? 4'd15 : 4'(i));
      push($sformatf("sat%0d", i), (i < 20) ? mk(2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1) : 11'b0);
      @(negedge clk);
      e = sb.pop_front();
      s = sat_sb.pop_front();
      checks++;
      if (ctl_s !== e.ctl || ctl_m !== e.ctl) begin
        errors++; $display("[TB] FAIL %s ctl got %b/%b want %b", e.tag, ctl_s, ctl_m, e.ctl);
      end
      checks++;
      if (cnt_s !== s) begin
        errors++; $display("[TB] FAIL %s sat StallCount got %0d want %0d", e.tag, cnt_s, s);
      end
      checks++;
      if (cnt_m !== e.cnt) begin
        errors++; $display("[TB] FAIL %s StallCount got %0d want %0d", e.tag, cnt_m, e.cnt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_forwarding();
    test_load_use();
    test_branch();
    test_wait_states();
    test_mem_wait0();
    test_reset_mid_wait();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
